// File: rtl/axi_sram_resp.sv
// axi_sram_resp -- single-port AXI4 slave in front of a 64-bit word SRAM.
//
// One transaction in flight at a time. Writes and reads share one FSM
// (IDLE, WR_DATA, WR_RESP, RD_DATA). When AW and AR are both valid in IDLE,
// a round-robin flag picks the winner. The flag starts at write and flips
// on every grant.
//
// Optional feature: define AXI_SRAM_RESP_WRAP_EN to enable WRAP bursts
// (len 1/3/7/15). Without it, every WRAP burst runs its full beat count with
// writes suppressed, read data 0 and response SLVERR.
//
// Ports
//   clk_i, arst_i              clock, asynchronous active-high reset
//   aw_* / w_* / b_*           write address, data and response channels
//   ar_* / r_*                 read address and data channels
// Parameters
//   ID_WIDTH, ADDR_WIDTH, DEPTH (number of 64-bit words)
module axi_sram_resp #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]            aw_len_i,
    input  logic [1:0]            aw_burst_i,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [63:0]           w_data_i,
    input  logic [7:0]            w_strb_i,
    input  logic                  w_last_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [1:0]            b_resp_o,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]            ar_len_i,
    input  logic [1:0]            ar_burst_i,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [63:0]           r_data_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_last_o,
    output logic                  r_valid_o,
    input  logic                  r_ready_i
);

`ifdef AXI_SRAM_RESP_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam int WORD_W = ADDR_WIDTH - 3;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

    state_t                state_q, state_d;
    logic                  prio_wr_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;
    logic [1:0]            burst_q;
    logic [1:0]            resp_q;

    logic [63:0] mem [DEPTH];

    // Burst types this build cannot serve: reserved type 3, and WRAP unless
    // enabled with a power-of-two beat count of 2..16.
    function automatic logic burst_bad(input logic [7:0] len, input logic [1:0] burst);
        logic legal_wrap;
        legal_wrap = WRAP_EN && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        if (burst == 2'd3)
            return 1'b1;
        if (burst == BURST_WRAP)
            return !legal_wrap;
        return 1'b0;
    endfunction

    // Address of the following beat. Word-granular from the second beat on,
    // so the low three bits drop out for INCR/WRAP.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0]            len,
                                                        input logic [1:0]            burst);
        logic [WORD_W-1:0] w, m, inc;
        w   = a[ADDR_WIDTH-1:3];
        m   = WORD_W'(len);
        inc = w + WORD_W'(1);
        case (burst)
            BURST_FIXED: return a;
            BURST_INCR:  return {inc, 3'b000};
            // len+1 is a power of two here, so len doubles as the window mask
            BURST_WRAP:  return {(w & ~m) | (inc & m), 3'b000};
            default:     return a;
        endcase
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:3] < WORD_W'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W+2:3];
    endfunction

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Grant selection: write wins unless a read is also pending and it is the read's turn.
    logic wr_sel, rd_sel;
    assign wr_sel = aw_valid_i && (prio_wr_q || !ar_valid_i);
    assign rd_sel = ar_valid_i && !wr_sel;

    // Write beat
    logic       w_fire, w_last_exp, w_bad, w_in, w_we;
    logic [1:0] w_beat_resp;
    assign w_fire     = (state_q == WR_DATA) && w_valid_i;
    assign w_last_exp = (cnt_q == len_q);
    assign w_bad      = burst_bad(len_q, burst_q);
    assign w_in       = in_range(addr_q);
    assign w_we       = w_fire && !w_bad && w_in;
    assign w_beat_resp = w_bad                    ? RESP_SLVERR :
                         !w_in                    ? RESP_DECERR :
                         (w_last_i != w_last_exp) ? RESP_SLVERR : RESP_OKAY;

    // Read beat: the first beat is fetched straight from the AR fields in the
    // grant cycle so it is on the bus one cycle after the handshake.
    logic                  rd_first, rd_adv, rd_done, rd_bad, rd_in;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_len;
    logic [1:0]            rd_burst;
    assign rd_first = (state_q == IDLE) && rd_sel;
    assign rd_done  = (state_q == RD_DATA) && r_valid_o && r_ready_i && r_last_o;
    assign rd_adv   = (state_q == RD_DATA) && r_valid_o && r_ready_i && !r_last_o;
    assign rd_addr  = rd_first ? ar_addr_i  : addr_q;
    assign rd_len   = rd_first ? ar_len_i   : len_q;
    assign rd_burst = rd_first ? ar_burst_i : burst_q;
    assign rd_bad   = burst_bad(rd_len, rd_burst);
    assign rd_in    = in_range(rd_addr);

    assign b_id_o   = id_q;
    assign b_resp_o = resp_q;

    always_comb begin
        state_d    = state_q;
        aw_ready_o = 1'b0;
        ar_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        case (state_q)
            IDLE: begin
                aw_ready_o = !arst_i && wr_sel;
                ar_ready_o = !arst_i && rd_sel;
                if (wr_sel)
                    state_d = WR_DATA;
                else if (rd_sel)
                    state_d = RD_DATA;
            end
            WR_DATA: begin
                w_ready_o = 1'b1;
                // beat counter decides the end of the burst, not w_last_i
                if (w_valid_i && w_last_exp)
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                b_valid_o = 1'b1;
                if (b_ready_i)
                    state_d = IDLE;
            end
            RD_DATA: begin
                if (rd_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory array is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            for (int b = 0; b < 8; b++)
                if (w_strb_i[b])
                    mem[word_idx(addr_q)][8*b +: 8] <= w_data_i[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= IDLE;
            prio_wr_q <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            burst_q   <= '0;
            resp_q    <= RESP_OKAY;
            r_valid_o <= 1'b0;
            r_last_o  <= 1'b0;
            r_data_o  <= '0;
            r_resp_o  <= RESP_OKAY;
            r_id_o    <= '0;
        end else begin
            state_q <= state_d;

            if ((state_q == IDLE) && (wr_sel || rd_sel))
                prio_wr_q <= !prio_wr_q;

            if ((state_q == IDLE) && wr_sel) begin
                id_q    <= aw_id_i;
                addr_q  <= aw_addr_i;
                len_q   <= aw_len_i;
                burst_q <= aw_burst_i;
                cnt_q   <= 8'd0;
                resp_q  <= RESP_OKAY;
            end

            if (w_fire) begin
                addr_q <= next_addr(addr_q, len_q, burst_q);
                cnt_q  <= cnt_q + 8'd1;
                resp_q <= worst(resp_q, w_beat_resp);
            end

            if (rd_first || rd_adv) begin
                r_valid_o <= 1'b1;
                r_data_o  <= (rd_bad || !rd_in) ? 64'd0 : mem[word_idx(rd_addr)];
                r_resp_o  <= rd_bad ? RESP_SLVERR : !rd_in ? RESP_DECERR : RESP_OKAY;
                addr_q    <= next_addr(rd_addr, rd_len, rd_burst);
            end

            if (rd_first) begin
                r_id_o   <= ar_id_i;
                len_q    <= ar_len_i;
                burst_q  <= ar_burst_i;
                cnt_q    <= 8'd1;
                r_last_o <= (ar_len_i == 8'd0);
            end else if (rd_adv) begin
                cnt_q    <= cnt_q + 8'd1;
                r_last_o <= (cnt_q == len_q);
            end else if (rd_done) begin
                r_valid_o <= 1'b0;
                r_last_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_resp.sv
module tb_axi_sram_resp;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic [3:0]  aw_id_i, ar_id_i, b_id_o, r_id_o;
    logic [63:0] aw_addr_i, ar_addr_i, w_data_i, r_data_o;
    logic [7:0]  aw_len_i, ar_len_i, w_strb_i;
    logic [1:0]  aw_burst_i, ar_burst_i, b_resp_o, r_resp_o;
    logic        aw_valid_i, aw_ready_o, w_last_i, w_valid_i, w_ready_o;
    logic        b_valid_o, b_ready_i, ar_valid_i, ar_ready_o;
    logic        r_last_o, r_valid_o, r_ready_i;

    axi_sram_resp dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
        .aw_burst_i(aw_burst_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
        .ar_burst_i(ar_burst_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
        .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0, n_fail = 0, n_total = 0;

    logic [63:0] got_data [4];
    logic [1:0]  got_resp [4];
    logic        got_last [4];
    logic [3:0]  got_id;
    logic        first_vld;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    int          waited;
    logic [63:0] wrap_exp [4];
    logic [1:0]  wrap_resp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic aw_req(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, output int wt);
        aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_burst_i = burst; aw_valid_i = 1'b1;
        wt = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (aw_ready_o) begin wt = i; break; end
        end
        check("aw_ready", 64'(wt >= 0), 64'd1);
        @(posedge clk_i); #1;
        aw_valid_i = 1'b0;
    endtask

    task automatic ar_req(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, output int wt);
        ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_burst_i = burst; ar_valid_i = 1'b1;
        wt = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (ar_ready_o) begin wt = i; break; end
        end
        check("ar_ready", 64'(wt >= 0), 64'd1);
        @(posedge clk_i); #1;
        ar_valid_i = 1'b0;
    endtask

    // Beat k carries d0*(k+1); w_last is raised on beat last_at.
    task automatic w_phase(input logic [63:0] d0, input logic [7:0] strb, input int len, input int last_at);
        logic ok;
        for (int k = 0; k <= len; k++) begin
            w_valid_i = 1'b1; w_data_i = d0 * 64'(k + 1); w_strb_i = strb; w_last_i = (k == last_at);
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk_i);
                if (w_ready_o) begin ok = 1'b1; break; end
            end
            check("w_ready", 64'(ok), 64'd1);
            @(posedge clk_i); #1;
        end
        w_valid_i = 1'b0; w_last_i = 1'b0;
    endtask

    task automatic b_phase(output logic [1:0] resp, output logic [3:0] id);
        logic ok;
        b_ready_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (b_valid_o) begin ok = 1'b1; break; end
        end
        check("b_valid", 64'(ok), 64'd1);
        resp = b_resp_o; id = b_id_o;
        @(posedge clk_i); #1;
        b_ready_i = 1'b0;
    endtask

    // Called right after ar_req; first negedge is the cycle after the AR handshake.
    task automatic r_phase(input int len, input logic stall);
        logic [63:0] hd;
        r_ready_i = 1'b0;
        @(negedge clk_i);
        first_vld = r_valid_o;
        for (int k = 0; k <= len; k++) begin
            for (int i = 0; i < 20 && !r_valid_o; i++) @(negedge clk_i);
            if (stall && k == 0) begin
                hd = r_data_o;
                @(negedge clk_i);
                check("r_hold_data", r_data_o, hd);
                check("r_hold_valid", 64'(r_valid_o), 64'd1);
            end
            got_data[k] = r_data_o; got_resp[k] = r_resp_o; got_last[k] = r_last_o; got_id = r_id_o;
            r_ready_i = 1'b1;
            @(posedge clk_i); #1;
            r_ready_i = 1'b0;
            if (k < len) @(negedge clk_i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef AXI_SRAM_RESP_WRAP_EN
        wrap_exp[0] = 64'h4000; wrap_exp[1] = 64'h1000; wrap_exp[2] = 64'h2000; wrap_exp[3] = 64'h3000;
        wrap_resp = 2'b00;
`else
        wrap_exp[0] = 64'h0; wrap_exp[1] = 64'h0; wrap_exp[2] = 64'h0; wrap_exp[3] = 64'h0;
        wrap_resp = 2'b10;
`endif
        // reset with both address channels requesting: nothing may be granted
        arst_i = 1'b1;
        aw_id_i = 0; aw_addr_i = 0; aw_len_i = 0; aw_burst_i = 0; aw_valid_i = 1'b1;
        ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_burst_i = 0; ar_valid_i = 1'b1;
        w_data_i = 0; w_strb_i = 0; w_last_i = 0; w_valid_i = 0; b_ready_i = 0; r_ready_i = 0;
        #12;
        check("rst_aw_ready", 64'(aw_ready_o), 0);
        check("rst_ar_ready", 64'(ar_ready_o), 0);
        check("rst_w_ready",  64'(w_ready_o), 0);
        check("rst_b_valid",  64'(b_valid_o), 0);
        check("rst_r_valid",  64'(r_valid_o), 0);
        check("rst_r_last",   64'(r_last_o), 0);
        check("rst_b_resp",   64'(b_resp_o), 0);
        check("rst_r_resp",   64'(r_resp_o), 0);
        check("rst_b_id",     64'(b_id_o), 0);
        check("rst_r_id",     64'(r_id_o), 0);
        check("rst_r_data",   r_data_o, 0);
        aw_valid_i = 1'b0; ar_valid_i = 1'b0;
        @(posedge clk_i); #1;
        arst_i = 1'b0;
        @(posedge clk_i); #1;

        // contention twice: write wins, the pending read follows
        for (int p = 0; p < 2; p++) begin
            ar_id_i = 4'(2 + 2*p); ar_addr_i = 64'h100 + 64'(8*p); ar_len_i = 0; ar_burst_i = 2'd1;
            aw_id_i = 4'(1 + 2*p); aw_addr_i = 64'h100 + 64'(8*p); aw_len_i = 0; aw_burst_i = 2'd1;
            ar_valid_i = 1'b1; aw_valid_i = 1'b1;
            @(negedge clk_i);
            check("both_aw_ready", 64'(aw_ready_o), 1);
            check("both_ar_ready", 64'(ar_ready_o), 0);
            @(posedge clk_i); #1;
            aw_valid_i = 1'b0;
            @(negedge clk_i);
            check("ar_blocked", 64'(ar_ready_o), 0);
            @(posedge clk_i); #1;
            w_phase(64'h5555 + 64'(p * 'h1111), 8'hFF, 0, 0);
            b_phase(bresp, bid);
            check("cont_b_resp", 64'(bresp), 0);
            check("cont_b_id", 64'(bid), 64'(1 + 2*p));
            ar_req(4'(2 + 2*p), 64'h100 + 64'(8*p), 0, 2'd1, waited);
            check("ar_second_b2b", 64'(waited), 0);
            r_phase(0, 1'b0);
            check("cont_r_data", got_data[0], 64'h5555 + 64'(p * 'h1111));
            check("cont_r_id", 64'(got_id), 64'(2 + 2*p));
        end

        // INCR write 0x40 len 3, then read back with a stall on the first beat
        aw_req(5, 64'h40, 3, 2'd1, waited);
        w_phase(64'h11, 8'hFF, 3, 3);
        b_phase(bresp, bid);
        check("incr_b_resp", 64'(bresp), 0);
        check("incr_b_id", 64'(bid), 5);
        ar_req(6, 64'h40, 3, 2'd1, waited);
        check("b2b_after_b", 64'(waited), 0);
        r_phase(3, 1'b1);
        check("incr_first_vld", 64'(first_vld), 1);
        check("incr_r_id", 64'(got_id), 6);
        for (int k = 0; k < 4; k++) begin
            check("incr_r_data", got_data[k], 64'h11 * 64'(k + 1));
            check("incr_r_last", 64'(got_last[k]), 64'(k == 3));
            check("incr_r_resp", 64'(got_resp[k]), 0);
        end

        // strobed write over a zeroed word
        aw_req(0, 64'h0, 0, 2'd1, waited);
        w_phase(64'h0, 8'hFF, 0, 0);
        b_phase(bresp, bid);
        aw_req(0, 64'h0, 0, 2'd1, waited);
        w_phase(64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 0, 0);
        b_phase(bresp, bid);
        check("strb_b_resp", 64'(bresp), 0);
        ar_req(1, 64'h0, 0, 2'd1, waited);
        r_phase(0, 1'b0);
        check("strb_r_data", got_data[0], 64'h0000_0000_CCCC_DDDD);

        // out of range: DEPTH*8 = 0x2000
        ar_req(7, 64'h2000, 0, 2'd1, waited);
        r_phase(0, 1'b0);
        check("oob_r_data", got_data[0], 0);
        check("oob_r_resp", 64'(got_resp[0]), 3);
        check("oob_r_last", 64'(got_last[0]), 1);
        aw_req(7, 64'h2000, 0, 2'd1, waited);
        w_phase(64'h99, 8'hFF, 0, 0);
        b_phase(bresp, bid);
        check("oob_b_resp", 64'(bresp), 3);

        // early w_last: both beats still taken, response SLVERR
        aw_req(8, 64'h80, 1, 2'd1, waited);
        w_phase(64'h77, 8'hFF, 1, 0);
        b_phase(bresp, bid);
        check("early_last_b_resp", 64'(bresp), 2);
        check("early_last_b_id", 64'(bid), 8);

        // WRAP read 0x18 len 3 over words 0x00..0x18 = 0x1000..0x4000
        aw_req(0, 64'h0, 3, 2'd1, waited);
        w_phase(64'h1000, 8'hFF, 3, 3);
        b_phase(bresp, bid);
        ar_req(9, 64'h18, 3, 2'd2, waited);
        r_phase(3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("wrap_r_data", got_data[k], wrap_exp[k]);
            check("wrap_r_resp", 64'(got_resp[k]), 64'(wrap_resp));
        end
        check("wrap_r_last", 64'(got_last[3]), 1);

        // reset in the middle of a read burst
        ar_req(10, 64'h40, 3, 2'd1, waited);
        @(negedge clk_i);
        check("mid_beat0", r_data_o, 64'h11);
        r_ready_i = 1'b1;
        @(posedge clk_i); #1;
        r_ready_i = 1'b0;
        @(negedge clk_i);
        check("mid_beat1", r_data_o, 64'h22);
        arst_i = 1'b1;
        #1;
        check("mid_rst_r_valid", 64'(r_valid_o), 0);
        check("mid_rst_r_data", r_data_o, 0);
        check("mid_rst_r_last", 64'(r_last_o), 0);
        #2;
        arst_i = 1'b0;
        @(posedge clk_i); #1;
        ar_req(11, 64'h48, 0, 2'd1, waited);
        check("post_rst_grant", 64'(waited), 0);
        r_phase(0, 1'b0);
        check("post_rst_r_data", got_data[0], 64'h22);
        check("post_rst_r_id", 64'(got_id), 11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
